// File: rtl/sr_shift_register.sv
// WIDTH-bit universal register: hold/load/shift, SR-style set/clear masks, counted multi-shift.
// Optional macro SR_SHIFT_ROTATE_EN adds i_rotate (shifts recirculate the exiting bit).
module sr_shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_serial_in,
    input  logic [WIDTH-1:0] i_set_mask,
    input  logic [WIDTH-1:0] i_clr_mask,
    input  logic             i_start,
    input  logic             i_dir,
    input  logic [CNT_W-1:0] i_shift_count,
`ifdef SR_SHIFT_ROTATE_EN
    input  logic             i_rotate,
`endif
    output logic [WIDTH-1:0] o_q,
    output logic             o_serial_out,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_n;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic             r_dir;
    logic             w_dir_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             r_busy;
    logic             r_done;
    logic             w_rot;

`ifdef SR_SHIFT_ROTATE_EN
    assign w_rot = i_rotate;
`else
    assign w_rot = 1'b0;
`endif

    assign w_shl = {r_q[WIDTH-2:0], w_rot ? r_q[WIDTH-1] : i_serial_in};
    assign w_shr = {w_rot ? r_q[0] : i_serial_in, r_q[WIDTH-1:1]};

    always_comb begin
        w_r       = r_q;
        w_dir_n   = r_dir;
        w_cnt_n   = r_cnt;
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_shift_count != '0) begin
                        w_cnt_n   = i_shift_count;
                        w_dir_n   = i_dir;
                        w_state_n = S_SHIFT;
                    end else begin
                        w_state_n = S_DONE;
                    end
                end else begin
                    unique case (i_op)
                        OP_HOLD: w_r = r_q;
                        OP_LOAD: w_r = i_d;
                        OP_SHL: begin
                            w_r     = w_shl;
                            w_dir_n = 1'b0;
                        end
                        OP_SHR: begin
                            w_r     = w_shr;
                            w_dir_n = 1'b1;
                        end
                        default: w_r = r_q;
                    endcase
                end
            end
            S_SHIFT: begin
                w_r     = r_dir ? w_shr : w_shl;
                w_cnt_n = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Both masks high is the SR "hold": keep the old bit, discard the op result.
    assign w_q_n = (w_r & ~(i_set_mask | i_clr_mask))
                 | (i_set_mask & ~i_clr_mask)
                 | (r_q & i_set_mask & i_clr_mask);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_q     <= RESET_VALUE;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_q     <= w_q_n;
            r_dir   <= w_dir_n;
            r_cnt   <= w_cnt_n;
            r_busy  <= (w_state_n == S_SHIFT);
            r_done  <= (w_state_n == S_DONE);
        end
    end

    assign o_q          = r_q;
    assign o_serial_out = r_dir ? r_q[0] : r_q[WIDTH-1];
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_sr_shift_register.sv
// Self-checking bench for sr_shift_register (WIDTH=8): directed table, corner sequences,
// and random stimulus against an arithmetic reference model.
module tb_sr_shift_register;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [1:0]   op;
    logic [W-1:0] d;
    logic         sin;
    logic [W-1:0] setm;
    logic [W-1:0] clrm;
    logic         start;
    logic         dir;
    logic [3:0]   cnt;
    logic         rotate;
    logic [W-1:0] q;
    logic         so;
    logic         busy;
    logic         done;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int mq   = 0;
    int mdir = 0;
    int mrem = 0;
    int mdone = 0;

    sr_shift_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_op         (op),
        .i_d          (d),
        .i_serial_in  (sin),
        .i_set_mask   (setm),
        .i_clr_mask   (clrm),
        .i_start      (start),
        .i_dir        (dir),
        .i_shift_count(cnt),
`ifdef SR_SHIFT_ROTATE_EN
        .i_rotate     (rotate),
`endif
        .o_q          (q),
        .o_serial_out (so),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] d;
        logic         sin;
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic         st;
        logic         dr;
        logic [3:0]   n;
        logic [W-1:0] eq;
        logic         eso;
        logic         eb;
        logic         ed;
    } vec_t;

    vec_t vec [16];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int shift1(input int v, input int right, input int ins_in, input int rot);
        int ins;
        if (right != 0) begin
            ins = (rot != 0) ? (v % 2) : ins_in;
            return v / 2 + ins * (1 << (W - 1));
        end
        ins = (rot != 0) ? (v / (1 << (W - 1))) : ins_in;
        return (v * 2 + ins) % (1 << W);
    endfunction

    task automatic model_step();
        int r;
        int dp;
        int rot;
        int nq;
        int sb;
        int cb;
`ifdef SR_SHIFT_ROTATE_EN
        rot = int'(rotate);
`else
        rot = 0;
`endif
        dp = mdone;
        mdone = 0;
        r = mq;
        if (mrem > 0) begin
            r = shift1(mq, mdir, int'(sin), rot);
            mrem--;
            if (mrem == 0) mdone = 1;
        end else if (dp != 0) begin
            r = mq;
        end else if (start) begin
            if (cnt == 0) mdone = 1;
            else begin
                mrem = int'(cnt);
                mdir = int'(dir);
            end
        end else begin
            case (op)
                2'd1: r = int'(d);
                2'd2: begin r = shift1(mq, 0, int'(sin), rot); mdir = 0; end
                2'd3: begin r = shift1(mq, 1, int'(sin), rot); mdir = 1; end
                default: r = mq;
            endcase
        end
        nq = 0;
        for (int i = 0; i < W; i++) begin
            sb = int'(setm[i]);
            cb = int'(clrm[i]);
            if (sb == 1 && cb == 0) nq += (1 << i);
            else if (sb == 1 && cb == 1) nq += mq & (1 << i);
            else if (sb == 0 && cb == 0) nq += r & (1 << i);
        end
        mq = nq;
    endtask

    function automatic int m_so();
        return (mdir != 0) ? (mq % 2) : (mq / (1 << (W - 1)));
    endfunction

    task automatic model_reset();
        mq = 0;
        mdir = 0;
        mrem = 0;
        mdone = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        op = 2'd0; d = '0; sin = 1'b0; setm = '0; clrm = '0;
        start = 1'b0; dir = 1'b0; cnt = '0; rotate = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".q"}, int'(q), mq);
        chk({tag, ".so"}, int'(so), m_so());
        chk({tag, ".busy"}, int'(busy), int'(mrem > 0));
        chk({tag, ".done"}, int'(done), mdone);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();

        //            op  d      sin s      c      st dr n     eq     so b  d
        vec[0]  = '{2'd1, 8'h81, 0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h81, 1, 0, 0};
        vec[1]  = '{2'd2, 8'h00, 1, 8'h00, 8'h00, 0, 0, 4'd0, 8'h03, 0, 0, 0};
        vec[2]  = '{2'd3, 8'h00, 0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h01, 1, 0, 0};
        vec[3]  = '{2'd1, 8'h0F, 0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h0F, 1, 0, 0};
        vec[4]  = '{2'd1, 8'hFF, 0, 8'h00, 8'h00, 1, 0, 4'd3, 8'h0F, 0, 1, 0};
        vec[5]  = '{2'd1, 8'hFF, 0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h1E, 0, 1, 0};
        vec[6]  = '{2'd1, 8'hFF, 0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h3C, 0, 1, 0};
        vec[7]  = '{2'd1, 8'hFF, 0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h78, 0, 0, 1};
        vec[8]  = '{2'd0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h78, 0, 0, 0};
        vec[9]  = '{2'd1, 8'h3C, 0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h3C, 0, 0, 0};
        vec[10] = '{2'd0, 8'h00, 0, 8'hF0, 8'h3C, 0, 0, 4'd0, 8'hF0, 1, 0, 0};
        vec[11] = '{2'd0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 4'd0, 8'hF0, 1, 0, 1};
        vec[12] = '{2'd0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 4'd2, 8'hF0, 1, 0, 0};
        vec[13] = '{2'd0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 4'd0, 8'hF0, 1, 0, 0};
        vec[14] = '{2'd3, 8'h00, 1, 8'h01, 8'h01, 0, 0, 4'd0, 8'hF8, 0, 0, 0};
        vec[15] = '{2'd2, 8'h00, 1, 8'h00, 8'h80, 0, 0, 4'd0, 8'h71, 0, 0, 0};

        #2;
        chk("reset.q", int'(q), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.so", int'(so), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            op = vec[i].op; d = vec[i].d; sin = vec[i].sin;
            setm = vec[i].s; clrm = vec[i].c;
            start = vec[i].st; dir = vec[i].dr; cnt = vec[i].n;
            step();
            chk($sformatf("vec%0d.q", i), int'(q), int'(vec[i].eq));
            chk($sformatf("vec%0d.so", i), int'(so), int'(vec[i].eso));
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(vec[i].eb));
            chk($sformatf("vec%0d.done", i), int'(done), int'(vec[i].ed));
        end
        idle_inputs();

        // reset in the middle of a counted shift
        op = 2'd1; d = 8'hA5;
        step();
        idle_inputs();
        start = 1'b1; cnt = 4'd5;
        step();
        idle_inputs();
        step();
        step();
        chk("midshift.busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midshift.q_async", int'(q), 0);
        chk("midshift.busy_async", int'(busy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midshift.no_done", int'(done), 0);
            chk("midshift.no_busy", int'(busy), 0);
        end

`ifdef SR_SHIFT_ROTATE_EN
        op = 2'd1; d = 8'h81;
        step();
        op = 2'd2; rotate = 1'b1;
        step();
        chk("rot.shl", int'(q), 8'h03);
        op = 2'd0; start = 1'b1; cnt = 4'd8; dir = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("rot.done", int'(done), 1);
        chk("rot.q", int'(q), 8'h03);
        idle_inputs();
        step();
`endif

        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            sin = 1'($urandom);
            setm = 8'($urandom & $urandom & $urandom);
            clrm = 8'($urandom & $urandom & $urandom);
            start = ($urandom_range(0, 3) == 0);
            dir = 1'($urandom);
            cnt = 4'($urandom_range(0, 15));
`ifdef SR_SHIFT_ROTATE_EN
            rotate = 1'($urandom);
`endif
            step();
            chk_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sr_shift_register.md
Name: sr_shift_register

Overview:
- Parametrised successor to the single-bit storage primitives: a WIDTH-bit universal register.
- Supports hold, parallel load, and single-step shift left/right.
- Supports per-bit set/clear masks, which generalise SR-latch behaviour to a clocked bank.
- A counted multi-shift engine with a busy/done handshake serves as the shared storage/serialiser element for later datapath blocks.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits).
- CNT_W, $clog2(WIDTH+1), width of shift_count; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- op  input  2  idle-cycle operation: 00 HOLD, 01 LOAD, 10 SHL, 11 SHR.
- d  input  WIDTH  parallel load data.
- serial_in  input  1  bit shifted into the vacated end.
- set_mask  input  WIDTH  per-bit set request.
- clr_mask  input  WIDTH  per-bit clear request.
- start  input  1  begin a counted multi-shift.
- dir  input  1  multi-shift direction, sampled with start: 0 left, 1 right.
- shift_count  input  CNT_W  number of shifts, sampled with start.
- q  output  WIDTH  register contents.
- serial_out  output  1  exiting bit: q[WIDTH-1] if dir_q=0, else q[0].
- busy  output  1  high while a multi-shift is in progress.
- done  output  1  one-cycle pulse when a multi-shift completes.

Behaviour:
- Reset (async, rst=1): immediately q=RESET_VALUE, dir_q=0, cnt=0, busy=0, done=0, state=IDLE. This applies mid-operation too; any multi-shift in progress is abandoned without a done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, shift_count!=0:
  - Latch cnt=shift_count and dir_q=dir; go to SHIFT; op is ignored this cycle; q is unchanged apart from masks.
  - busy rises on the next edge.
- IDLE, start=1, shift_count=0: go to DONE with no shift; busy never asserts.
- IDLE, start=0: apply op.
  - LOAD: q=d.
  - SHL: q={q[WIDTH-2:0],serial_in}, and dir_q=0.
  - SHR: q={serial_in,q[WIDTH-1:1]}, and dir_q=1.
  - HOLD: no change.
- SHIFT:
  - Each cycle, shift one position in direction dir_q, inserting serial_in, and decrement cnt.
  - When cnt==1 this cycle, go to DONE.
  - op and start are ignored.
  - busy=1 throughout; a shift_count of N yields exactly N busy cycles.
- DONE: done=1 and busy=0 for one cycle, with q held except for masks; then return to IDLE.
  - start in DONE is ignored; it must be re-presented in IDLE.
- Masks are applied every cycle in every state, after the op/shift result r:
  - set=1, clr=0: bit becomes 1.
  - set=0, clr=1: bit becomes 0.
  - set=1, clr=1: bit holds its current q value (SR hold), discarding r.
  - set=0, clr=0: bit takes r.
- shift_count > WIDTH is legal; the extra shifts keep inserting serial_in.
- All outputs are registered except serial_out, which is combinational from q and dir_q.

Optional Feature:
- Macro: SR_SHIFT_ROTATE_EN.
- Defined:
  - Adds input port rotate (1 bit).
  - When rotate=1, every shift (single-step or counted) re-inserts the exiting bit instead of serial_in.
  - rotate is sampled every cycle.
- Undefined: port absent; shifts always insert serial_in.

Test Plan:
- Reset mid-shift (WIDTH=8, RESET_VALUE=0): LOAD 0xA5; start, count 5, dir 0; assert rst 2 cycles later -> q=0x00, busy=0 immediately; no done pulse after release.
- Single steps: LOAD 0x81; SHL with serial_in=1 -> q=0x03, serial_out=0; SHR with serial_in=0 -> q=0x01, serial_out=1.
- Counted shift: q=0x0F; start, count 3, dir 0, serial_in=0 -> busy high for 3 cycles, q=0x1E, 0x3C, 0x78; done=1 for one cycle, busy=0; op=LOAD during busy is ignored.
- Masks: q=0x3C, op HOLD, set_mask=0xF0, clr_mask=0x3C -> bits 7,6 set, bits 5,4 hold, bits 3,2 cleared -> q=0xF0.
- Zero count: start with count 0 -> busy stays 0; done pulses on the following cycle; q unchanged.
- Rotate (macro defined): q=0x81, rotate=1, SHL -> 0x03; start, count 8, rotate=1 -> q returns to 0x03 after done.
